// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data-cache controller.
// Drives a 32-line tag SRAM and data SRAM (combinational read, write on clock)
// and a line-wide memory port with a one-cycle acknowledge.
module dcache_controller #(
   parameter int LINE_W = 256,
   parameter int IDX_W  = 5,
   parameter int TAG_W  = 22
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          p1_addr_i,
   input  logic [31:0]          p1_data_i,
   input  logic                 p1_MemRead_i,
   input  logic                 p1_MemWrite_i,
   output logic [31:0]          p1_data_o,
   output logic                 p1_stall_o,
   output logic [IDX_W-1:0]     sram_addr_o,
   output logic                 sram_enable_o,
   output logic                 sram_write_o,
   input  logic [TAG_W+1:0]     tag_i,
   output logic [TAG_W+1:0]     tag_o,
   input  logic [LINE_W-1:0]    line_i,
   output logic [LINE_W-1:0]    line_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_W-1:0]    mem_data_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   input  logic [LINE_W-1:0]    mem_data_i,
   input  logic                 mem_ack_i
);

   localparam int OFF_W  = 32 - TAG_W - IDX_W;
   localparam int WORD_W = OFF_W - 2;
   localparam int WORDS  = LINE_W / 32;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_MISS, S_WBACK, S_REFILL, S_FILLED
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     cnt_q, cnt_d;
   logic [31:0]          wb_addr_q, wb_addr_d;
   logic [LINE_W-1:0]    wb_line_q, wb_line_d;
   logic [31:0]          p1_data_q, p1_data_d;
   logic                 gap_q, gap_d;

   logic [TAG_W-1:0]     addr_tag;
   logic [IDX_W-1:0]     addr_idx;
   logic [WORD_W-1:0]    addr_word;
   logic                 req, is_write, hit, victim_dirty;
   logic [31:0]          line_words [WORDS];
   logic [LINE_W-1:0]    merged_line;
   logic                 unused_addr_bits;

   assign addr_tag     = p1_addr_i[31 -: TAG_W];
   assign addr_idx     = p1_addr_i[OFF_W +: IDX_W];
   assign addr_word    = p1_addr_i[2 +: WORD_W];
   assign req          = p1_MemRead_i | p1_MemWrite_i;
   assign is_write     = p1_MemWrite_i;
   assign hit          = tag_i[TAG_W+1] & (tag_i[TAG_W-1:0] == addr_tag);
   assign victim_dirty = tag_i[TAG_W+1] & tag_i[TAG_W];
   assign unused_addr_bits = &{1'b0, p1_addr_i[1:0]};

   // Split the SRAM line into words and build the store-merged line
   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         assign line_words[gi] = line_i[gi*32 +: 32];
         assign merged_line[gi*32 +: 32] =
            (addr_word == WORD_W'(gi)) ? p1_data_i : line_i[gi*32 +: 32];
      end
   endgenerate

   // Next-state and output decode for the controller FSM
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wb_addr_d     = wb_addr_q;
      wb_line_d     = wb_line_q;
      p1_data_d     = p1_data_q;
      gap_d         = 1'b0;
      p1_data_o     = p1_data_q;
      p1_stall_o    = 1'b1;
      sram_addr_o   = addr_idx;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      tag_o         = '0;
      line_o        = '0;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;

      case (state_q)
         S_INIT: begin
            sram_addr_o   = cnt_q;
            sram_enable_o = 1'b1;
            sram_write_o  = 1'b1;
            cnt_d         = cnt_q + IDX_W'(1);
            if (cnt_q == '1) state_d = S_IDLE;
         end
         S_IDLE: begin
            p1_stall_o    = 1'b0;
            sram_enable_o = req;
            if (req) begin
               if (hit) begin
                  if (is_write) begin
                     sram_write_o = 1'b1;
                     line_o       = merged_line;
                     tag_o        = {2'b11, addr_tag};
                  end else begin
                     p1_data_o = line_words[addr_word];
                     p1_data_d = line_words[addr_word];
                  end
               end else begin
                  p1_stall_o = 1'b1;
                  state_d    = S_MISS;
               end
            end
         end
         S_MISS: begin
            sram_enable_o = 1'b1;
            if (victim_dirty) begin
               wb_addr_d = {tag_i[TAG_W-1:0], addr_idx, {OFF_W{1'b0}}};
               wb_line_d = line_i;
               state_d   = S_WBACK;
            end else begin
               state_d = S_REFILL;
            end
         end
         S_WBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = wb_addr_q;
            mem_data_o   = wb_line_q;
            if (mem_ack_i) begin
               gap_d   = 1'b1;
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            sram_enable_o = 1'b1;
            // First cycle after a writeback keeps the request low so the
            // memory sees a clean boundary between the two transactions.
            if (!gap_q) begin
               mem_enable_o = 1'b1;
               mem_addr_o   = {addr_tag, addr_idx, {OFF_W{1'b0}}};
               if (mem_ack_i) begin
                  sram_write_o = 1'b1;
                  line_o       = mem_data_i;
                  tag_o        = {2'b10, addr_tag};
                  state_d      = S_FILLED;
               end
            end
         end
         S_FILLED: begin
            sram_enable_o = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase

      // While reset is held nothing may be written or requested
      if (rst_i) begin
         mem_enable_o = 1'b0;
         mem_write_o  = 1'b0;
         sram_write_o = 1'b0;
         p1_data_o    = 32'd0;
      end
   end

   // State, sweep counter, writeback buffer and load-data hold registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_INIT;
         cnt_q     <= '0;
         wb_addr_q <= '0;
         wb_line_q <= '0;
         p1_data_q <= '0;
         gap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wb_addr_q <= wb_addr_d;
         wb_line_q <= wb_line_d;
         p1_data_q <= p1_data_d;
         gap_q     <= gap_d;
      end
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data-cache controller. It sits between the CPU MEM stage and the 32-entry x 256-bit data SRAM plus a companion tag SRAM.
- It decodes CPU word accesses, detects hit or miss, and merges store words into lines.
- On a miss it writes back the dirty victim, refills the line from data memory, and stalls the pipeline until the access completes.

Parameters:
LINE_W, 256, cache line width in bits (32 bytes, 8 words)
IDX_W, 5, index width (32 lines)
TAG_W, 22, address tag width (addr[31:10])

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
p1_addr_i  in  32  CPU byte address (word aligned)
p1_data_i  in  32  CPU store data
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request
p1_data_o  out  32  load data
p1_stall_o  out  1  pipeline stall
sram_addr_o  out  5  index to tag and data SRAMs
sram_enable_o  out  1  SRAM enable
sram_write_o  out  1  SRAM write strobe (tag and data written together)
tag_i  in  24  tag SRAM read {valid, dirty, tag[21:0]}
tag_o  out  24  tag SRAM write data
line_i  in  256  data SRAM read line (combinational read)
line_o  out  256  data SRAM write line
mem_addr_o  out  32  memory line address, bits[4:0]=0
mem_data_o  out  256  writeback line
mem_enable_o  out  1  memory request
mem_write_o  out  1  1=write, 0=read
mem_data_i  in  256  refill line
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Address split: tag=addr[31:10], index=addr[9:5], word=addr[4:2]. Word w occupies line bits [32w+31:32w].
- req = MemRead|MemWrite. If both are asserted, the access is treated as a write.
- hit = tag_i[23] & (tag_i[21:0]==tag).
- States: INIT, IDLE, MISS, WBACK, REFILL, FILLED.

Reset:
- Next state is INIT. The counter clears to 0.
- mem_enable_o=0, mem_write_o=0, sram_write_o=0, p1_data_o=0.
- Any in-flight memory transaction is abandoned: mem_enable_o is low from the cycle after reset is sampled.

INIT:
- Sweeps indices 0..31.
- Each cycle: sram_enable_o=1, sram_write_o=1, tag_o=0, line_o=0, sram_addr_o=counter.
- After index 31 is written (32 cycles), go to IDLE.
- p1_stall_o=1 throughout.

IDLE:
- sram_addr_o=index; sram_enable_o=req.
- Read hit: p1_data_o = selected word of line_i, combinationally in the same cycle; p1_stall_o=0.
- Write hit: in the same cycle, sram_write_o=1, line_o = line_i with the word replaced by p1_data_i, tag_o={1,1,tag}; p1_stall_o=0.
- Miss: p1_stall_o=1 (combinational); next state MISS.
- No request: p1_stall_o=0; p1_data_o holds its last value.

MISS:
- Victim is valid and dirty: latch victim address {tag_i[21:0], index, 5'b0} and line_i into writeback registers; go to WBACK.
- Otherwise: go to REFILL.

WBACK:
- mem_enable_o=1, mem_write_o=1, mem_addr_o=victim address, mem_data_o=victim line, all held stable until mem_ack_i.
- On mem_ack_i: go to REFILL; mem_enable_o=0 for one cycle (FSM passes through a deasserted cycle).

REFILL:
- mem_enable_o=1, mem_write_o=0, mem_addr_o={tag, index, 5'b0}.
- On mem_ack_i, in the same cycle: sram_write_o=1, line_o=mem_data_i, tag_o={1,0,tag}; go to FILLED.

FILLED:
- One bubble cycle with no memory request; go to IDLE.
- The access now hits: a load returns data, a store merges and sets dirty.

Stall and protocol rules:
- p1_stall_o=1 in every state except IDLE.
- The CPU holds address, data and request stable while stalled.
- mem_ack_i outside WBACK/REFILL is ignored.
- A miss into a line with valid=1, dirty=0 skips WBACK.
- Index 31, tag all-ones, word 7 must work; there is no wrap hazard.
- Memory latency is unbounded, minimum 1 cycle after request.

Test Plan:
- Reset, then load 0x0000_0000: stall for 32 INIT cycles, then miss. REFILL addr 0x0, mem returns a line with word0=0xDEADBEEF. After FILLED, p1_data_o=0xDEADBEEF and stall drops.
- Store 0x12345678 to 0x0000_0004 (hit): no stall. Tag[0]={1,1,0}, line word1=0x12345678, other words unchanged.
- Load 0x0000_0400 (same index 0, tag 1, victim dirty): WBACK to addr 0x0 carrying the modified line, ack after 5 cycles. Then REFILL addr 0x400; the load completes with tag[0]={1,0,1}.
- Load 0xFFFF_FFFC on a clean miss: no WBACK. REFILL addr 0xFFFF_FFE0, index 31, word 7 returned.
- Store miss to a clean line 0x0000_0020: refill, then merge. Tag[1]={1,1,0}, stall asserted for exactly REFILL wait + 2 cycles.
- Assert rst_i during WBACK with mem_enable_o=1: mem_enable_o=0 next cycle, FSM enters INIT, and all 32 tags are zero after the sweep.
